// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one single-ported memory between the instruction
// fetch requester (I) and the load/store requester (D). One transaction is in
// flight at a time. D has priority unless I has been left waiting too long.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch requester
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // load/store requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  // memory port
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  // current transaction owner: 00 idle, 01 I, 10 D
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  state_e     state_q;
  logic [3:0] wait_cnt_q;
  logic       starve;

  // Arbitration: D wins unless I has waited Limit cycles; grants only from idle
  always_comb begin
    starve = i_req && (wait_cnt_q >= Limit);
    d_gnt  = (state_q == StIdle) && d_req && !starve;
    i_gnt  = (state_q == StIdle) && i_req && !d_gnt;
  end

  // Counts cycles I is left waiting with its request up; saturates at 15
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else if (!i_req || i_gnt) begin
      wait_cnt_q <= '0;
    end else if (wait_cnt_q != 4'hf) begin
      wait_cnt_q <= wait_cnt_q + 4'd1;
    end
  end

  // Transaction FSM: latch winner into the memory port, return data on ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      owner    <= 2'b00;
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_done   <= 1'b0;
      d_rdata  <= '0;
    end else begin
      // completion pulses last exactly one cycle
      i_rvalid <= 1'b0;
      d_done   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (d_gnt) begin
            state_q <= StBusyD;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            owner   <= 2'b10;
          end else if (i_gnt) begin
            // fetches are always reads with no write data
            state_q <= StBusyI;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            owner   <= 2'b01;
          end
        end
        StBusyI: begin
          if (m_req && m_ack) begin
            state_q  <= StIdle;
            m_req    <= 1'b0;
            owner    <= 2'b00;
            i_rdata  <= m_rdata;
            i_rvalid <= 1'b1;
          end
        end
        StBusyD: begin
          if (m_req && m_ack) begin
            state_q <= StIdle;
            m_req   <= 1'b0;
            owner   <= 2'b00;
            d_done  <= 1'b1;
            // stores leave the last load data visible
            if (!m_we) begin
              d_rdata <= m_rdata;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          m_req   <= 1'b0;
          owner   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural memory with configurable wait
// states, per-requester expectation queues filled at grant time, a vector
// table of arbitration cases and hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_done;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_gnt   (i_gnt),
    .i_rvalid(i_rvalid),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_gnt   (d_gnt),
    .d_done  (d_done),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_rdata (m_rdata),
    .owner   (owner)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
  endtask

  // Behavioural memory: unwritten words read back as a pattern of the address
  logic [31:0] mem_arr [logic [31:0]];
  int          mem_wait = 0;
  int          busy_cnt = 0;
  bit          spurious = 0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Scoreboard state
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] last_load = '0;
  logic [31:0] last_i_val = '0;
  bit          i_hold = 0, d_hold = 0;
  int          cyc = 0;
  int          i_pulses = 0, d_pulses = 0;

  // One clock cycle: sample grants at negedge, then update requesters, memory
  // and scoreboard just after the rising edge.
  task automatic tick();
    bit ig, dg;
    @(negedge clk);
    ig = i_gnt;
    dg = d_gnt;
    check("gnt_onehot", 32'(ig & dg), 0);
    if (ig) exp_i_q.push_back(mem_read(i_addr));
    if (dg) begin
      if (!d_we) last_load = mem_read(d_addr);
      exp_d_q.push_back(last_load);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ig && !i_hold) i_req = 1'b0;
    if (dg && !d_hold) d_req = 1'b0;
    if (m_req) begin
      if (busy_cnt >= mem_wait) begin
        m_ack = 1'b1;
        if (m_we) begin
          mem_arr[m_addr] = m_wdata;
          m_rdata = $urandom;
        end else begin
          m_rdata = mem_read(m_addr);
        end
        busy_cnt = 0;
      end else begin
        m_ack   = 1'b0;
        m_rdata = $urandom;
        busy_cnt++;
      end
    end else begin
      m_ack    = spurious;
      m_rdata  = spurious ? 32'hFFFF_FFFF : $urandom;
      busy_cnt = 0;
    end
    if (i_rvalid) begin
      i_pulses++;
      check("i_rvalid_expected", 32'(exp_i_q.size() != 0), 1);
      if (exp_i_q.size() != 0) begin
        last_i_val = exp_i_q.pop_front();
        check("i_rdata", i_rdata, last_i_val);
      end
    end
    if (d_done) begin
      d_pulses++;
      check("d_done_expected", 32'(exp_d_q.size() != 0), 1);
      if (exp_d_q.size() != 0) check("d_rdata", d_rdata, exp_d_q.pop_front());
    end
  endtask

  // Run until all requests are served, bounded
  task automatic drain(input int max_cycles);
    int n = 0;
    while ((exp_i_q.size() != 0 || exp_d_q.size() != 0 || i_req || d_req) && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_in_time", 32'(n < max_cycles), 1);
  endtask

  typedef struct {
    bit          ir;
    bit          dr;
    bit          dwe;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    int          mw;
    bit          exp_ig;
    bit          exp_dg;
    logic [1:0]  exp_owner;
    logic [31:0] exp_maddr;
    bit          exp_mwe;
    logic [31:0] exp_mwd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int c0, dp, ip;
    vecs[0] = '{1, 0, 0, 32'h1000, 32'h0,    32'h0,        0, 1, 0, 2'b01, 32'h1000, 0, 32'h0};
    vecs[1] = '{0, 1, 0, 32'h0,    32'h2000, 32'h0,        1, 0, 1, 2'b10, 32'h2000, 0, 32'h0};
    vecs[2] = '{0, 1, 1, 32'h0,    32'h2000, 32'hCAFE_F00D, 3, 0, 1, 2'b10, 32'h2000, 1,
                32'hCAFE_F00D};
    vecs[3] = '{1, 1, 0, 32'h1004, 32'h2000, 32'h1111_1111, 0, 0, 1, 2'b10, 32'h2000, 0,
                32'h1111_1111};
    vecs[4] = '{1, 1, 1, 32'h1008, 32'h3000, 32'h0000_55AA, 2, 0, 1, 2'b10, 32'h3000, 1,
                32'h0000_55AA};
    vecs[5] = '{1, 0, 1, 32'h3000, 32'h4000, 32'h7777_7777, 1, 1, 0, 2'b01, 32'h3000, 0, 32'h0};

    reset = 1'b0;
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    m_ack = 0; m_rdata = '0;

    // Reset state
    #12;
    check("rst_m_req", 32'(m_req), 0);
    check("rst_m_we", 32'(m_we), 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_i_rvalid", 32'(i_rvalid), 0);
    check("rst_d_done", 32'(d_done), 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    reset = 1'b1;
    tick();

    // Single fetch, memory acks in the first cycle
    mem_arr[32'h40] = 32'h2409_0005;
    mem_wait = 0;
    i_req = 1; i_addr = 32'h40;
    #1;
    check("fetch_i_gnt", 32'(i_gnt), 1);
    check("fetch_d_gnt", 32'(d_gnt), 0);
    tick();
    check("fetch_m_req", 32'(m_req), 1);
    check("fetch_m_addr", m_addr, 32'h40);
    check("fetch_m_we", 32'(m_we), 0);
    check("fetch_owner", 32'(owner), 1);
    tick();
    check("fetch_i_rvalid", 32'(i_rvalid), 1);
    check("fetch_i_rdata", i_rdata, 32'h2409_0005);
    check("fetch_owner_idle", 32'(owner), 0);
    tick();
    check("fetch_pulse_one_cycle", 32'(i_rvalid), 0);
    check("fetch_i_rdata_hold", i_rdata, 32'h2409_0005);

    // Store then load with two wait states, back to back
    mem_wait = 2;
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    #1;
    check("st_d_gnt", 32'(d_gnt), 1);
    dp = d_pulses;
    tick();
    check("st_m_we", 32'(m_we), 1);
    check("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
    check("st_owner", 32'(owner), 2);
    repeat (3) tick();
    check("st_d_done_cycle4", 32'(d_done), 1);
    check("st_single_pulse", 32'(d_pulses - dp), 1);
    d_req = 1; d_we = 0; d_addr = 32'h100;
    #1;
    check("ld_b2b_d_gnt", 32'(d_gnt), 1);
    repeat (4) tick();
    check("ld_d_done_4later", 32'(d_done), 1);
    check("ld_d_rdata", d_rdata, 32'hDEAD_BEEF);
    check("ld_single_pulse", 32'(d_pulses - dp), 2);
    drain(20);

    // Simultaneous requests: D first, then I in D's completion cycle
    mem_wait = 1;
    i_req = 1; i_addr = 32'h200;
    d_req = 1; d_we = 0; d_addr = 32'h300;
    #1;
    check("sim_d_gnt", 32'(d_gnt), 1);
    check("sim_i_gnt", 32'(i_gnt), 0);
    tick();
    check("sim_owner_d", 32'(owner), 2);
    repeat (2) tick();
    check("sim_d_done", 32'(d_done), 1);
    #1;
    check("sim_i_gnt_after_d", 32'(i_gnt), 1);
    tick();
    check("sim_owner_i", 32'(owner), 1);
    drain(20);

    // Starvation: D requests continuously, I must win after 4 waiting cycles
    mem_wait = 0;
    d_hold = 1;
    d_req = 1; d_we = 0; d_addr = 32'h400;
    i_req = 1; i_addr = 32'h500;
    c0 = cyc;
    #1;
    while (!i_gnt && (cyc - c0) < 20) begin
      tick();
      #1;
    end
    check("starve_i_wins_cycle", 32'(cyc - c0), 4);
    check("starve_i_gnt", 32'(i_gnt), 1);
    check("starve_d_gnt", 32'(d_gnt), 0);
    tick();
    i_req = 1; i_addr = 32'h504;
    tick();
    #1;
    // counter restarted after I's grant, so D wins again
    check("starve_cnt_cleared_d_gnt", 32'(d_gnt), 1);
    check("starve_cnt_cleared_i_gnt", 32'(i_gnt), 0);
    d_hold = 0;
    drain(40);

    // Vector table: arbitration and port capture from idle with wait_cnt clear
    foreach (vecs[k]) begin
      mem_wait = vecs[k].mw;
      i_req = vecs[k].ir; i_addr = vecs[k].ia;
      d_req = vecs[k].dr; d_we = vecs[k].dwe; d_addr = vecs[k].da; d_wdata = vecs[k].wd;
      #1;
      check($sformatf("vec%0d_i_gnt", k), 32'(i_gnt), 32'(vecs[k].exp_ig));
      check($sformatf("vec%0d_d_gnt", k), 32'(d_gnt), 32'(vecs[k].exp_dg));
      tick();
      check($sformatf("vec%0d_m_req", k), 32'(m_req), 1);
      check($sformatf("vec%0d_owner", k), 32'(owner), 32'(vecs[k].exp_owner));
      check($sformatf("vec%0d_m_addr", k), m_addr, vecs[k].exp_maddr);
      check($sformatf("vec%0d_m_we", k), 32'(m_we), 32'(vecs[k].exp_mwe));
      check($sformatf("vec%0d_m_wdata", k), m_wdata, vecs[k].exp_mwd);
      drain(60);
    end

    // Reset in the middle of a store
    mem_wait = 6;
    d_req = 1; d_we = 1; d_addr = 32'h600; d_wdata = 32'h1234_5678;
    tick();
    tick();
    check("mid_m_req_before", 32'(m_req), 1);
    #3;
    reset = 1'b0;
    #1;
    check("mid_m_req", 32'(m_req), 0);
    check("mid_owner", 32'(owner), 0);
    check("mid_d_done", 32'(d_done), 0);
    check("mid_i_rvalid", 32'(i_rvalid), 0);
    exp_d_q.delete();
    exp_i_q.delete();
    last_load = '0;
    last_i_val = '0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    dp = d_pulses;
    repeat (10) tick();
    check("mid_no_d_done", 32'(d_pulses - dp), 0);
    check("mid_d_rdata_cleared", d_rdata, 0);

    // Spurious ack while idle
    spurious = 1;
    dp = d_pulses;
    ip = i_pulses;
    repeat (3) tick();
    check("spur_no_d_done", 32'(d_pulses - dp), 0);
    check("spur_no_i_rvalid", 32'(i_pulses - ip), 0);
    check("spur_owner", 32'(owner), 0);
    check("spur_m_req", 32'(m_req), 0);
    check("spur_i_rdata", i_rdata, last_i_val);
    check("spur_d_rdata", d_rdata, last_load);
    spurious = 0;

    // Abandoned store never reached memory
    mem_wait = 0;
    d_req = 1; d_we = 0; d_addr = 32'h600;
    drain(20);
    check("final_queues_empty", 32'(exp_i_q.size() + exp_d_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the core's instruction-fetch requester (I) and load/store requester (D).
- Sits between the mips core fetch/memory stages and the single-ported instruction/data memory.
- Grants one transaction at a time and gives data priority, bounded by an instruction anti-starvation limit.
- Registers the memory request and returns read data and a completion pulse to the owning requester.

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width for all ports.
- STARVE_LIMIT, 4, number of cycles I may wait with i_req high before it beats D; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset; 0 resets the block.
- i_req  in  1  instruction read request, held until i_gnt.
- i_addr  in  ADDR_W  fetch address, stable while i_req=1.
- i_gnt  out  1  combinational; request accepted this cycle.
- i_rvalid  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request, held until d_gnt.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  combinational; request accepted this cycle.
- d_done  out  1  one-cycle pulse on load or store completion.
- d_rdata  out  DATA_W  load data; valid with d_done when d_we was 0.
- m_req  out  1  registered memory request.
- m_we  out  1  registered write enable.
- m_addr  out  ADDR_W  registered address.
- m_wdata  out  DATA_W  registered store data.
- m_ack  in  1  memory completes the transaction; sampled only while m_req=1.
- m_rdata  in  DATA_W  read data, valid with m_ack.
- owner  out  2  00 idle, 01 I busy, 10 D busy.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE and every output register clears to 0, including m_* outputs, rdata outputs, the i_rvalid and d_done pulses, and the wait counter.
  - Reset asserted mid-transaction abandons the transaction: m_req drops immediately and no completion pulse is issued.
- FSM states and transitions:
  - IDLE: arbitrate.
  - IDLE -> BUSY_I or BUSY_D on a grant.
  - BUSY_x -> IDLE on the edge where m_req=1 and m_ack=1.
- Arbitration (IDLE only, combinational):
  - starve = i_req && (wait_cnt >= STARVE_LIMIT).
  - d_gnt = d_req && !starve.
  - i_gnt = i_req && !d_gnt.
  - Both grants are 0 outside IDLE; at most one grant is high per cycle.
- Grant edge:
  - Latch the winner's addr, we (I forces we=0) and wdata (I forces 0) into m_*.
  - m_req=1 from the next cycle.
  - owner is updated to the winner.
- BUSY: m_* held constant until m_ack. m_ack while m_req=0 is ignored.
- Ack edge:
  - m_req <- 0; state <- IDLE; owner <- 00.
  - If BUSY_I: i_rdata <- m_rdata and i_rvalid=1 for exactly the next cycle.
  - If BUSY_D: d_done=1 for exactly the next cycle. If the transaction was a load, d_rdata <- m_rdata; if a store, d_rdata holds its previous value.
  - A new grant may occur in the same cycle the completion pulse is high, giving back-to-back transactions.
- Latency:
  - Grant cycle n, m_req high cycle n+1.
  - If m_ack arrives in n+1, the pulse is in n+2; minimum req-to-response latency is 2 cycles.
  - Memory wait states add 1 cycle each; there is no timeout.
- wait_cnt:
  - Increments (saturating at 15) each cycle i_req=1 and i_gnt=0.
  - Clears when i_gnt=1 or i_req=0.
- Requester rule: a requester that drops req before its gnt cancels the request without side effects. Changing addr/data while req=1 and ungranted is legal; the value captured is the one present in the grant cycle.
- rdata outputs hold their last value between pulses.

Test Plan:
- Single fetch: i_req, i_addr=0x0000_0040; memory acks 1st cycle with 0x2409_0005 -> i_gnt in cycle 0, m_req/m_addr=0x40/m_we=0 in cycle 1, i_rvalid=1 with i_rdata=0x2409_0005 in cycle 2.
- Store then load with 2 wait states: d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, then d_we=0 at 0x100, memory returns 0xDEAD_BEEF -> store d_done in cycle 4, m_we=1 during the store; load d_done with d_rdata=0xDEAD_BEEF 4 cycles later.
- Simultaneous i_req and d_req in IDLE with wait_cnt=0 -> d_gnt=1 and i_gnt=0; I is served immediately after D's d_done cycle if D has no new request.
- Starvation: d_req held continuously, i_req held, memory acks after 1 cycle -> at the first IDLE cycle with wait_cnt>=4, i_gnt=1 and d_gnt=0; wait_cnt returns to 0 afterward.
- Reset mid-transaction: reset=0 while m_req=1 in BUSY_D, asynchronously between edges -> m_req, owner, d_done and i_rvalid go to 0 immediately; after release, no d_done is ever produced for the abandoned store.
- Spurious m_ack=1 in IDLE with m_rdata=0xFFFF_FFFF -> no i_rvalid or d_done pulse, rdata outputs unchanged, state stays IDLE.
